// File: rtl/interrupt_ctrl.sv
// Four-source rising-edge interrupt controller with fixed priority (source 0 highest) and one-cycle gap between services.
// Optional per-source mask register enabled by defining INTC_MASK_EN.
module interrupt_ctrl #(
    parameter logic [31:0] ISR_BASE   = 32'h0000_0000,
    parameter logic [31:0] ISR_STRIDE = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  irq_src,
    input  logic        irq_ack,
`ifdef INTC_MASK_EN
    input  logic        mask_we,
    input  logic [3:0]  mask_wd,
`endif
    output logic        irq,
    output logic [31:0] irq_addr,
    output logic [1:0]  irq_id,
    output logic [3:0]  pending
);

    localparam int unsigned N_SRC  = 4;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_n;
    logic [N_SRC-1:0]    src_q;
    logic [N_SRC-1:0]    held_q;
    logic [N_SRC-1:0]    src_edge;
    logic [N_SRC-1:0]    mask;
    logic [N_SRC-1:0]    req;
    logic [N_SRC-1:0]    clr;
    logic [N_SRC-1:0]    pend_n;
    logic                win_vld;
    logic [ID_W-1:0]     win_id;
    logic                irq_n;
    logic [ID_W-1:0]     irq_id_n;
    logic [ADDR_W-1:0]   irq_addr_n;

`ifdef INTC_MASK_EN
    logic [N_SRC-1:0]    mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '1;
        end else if (mask_we) begin
            mask_q <= mask_wd;
        end
    end

    assign mask = mask_q;
`else
    assign mask = '1;
`endif

    // held_q blocks a line that was already high at reset until it has dropped once
    assign src_edge = irq_src & ~src_q & ~held_q;
    assign req      = pending & mask;

    // Fixed-priority arbiter: lowest set index wins
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (req[i] && !win_vld) begin
                win_vld = 1'b1;
                win_id  = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            irq      <= 1'b0;
            irq_id   <= '0;
            irq_addr <= '0;
        end else begin
            state_q  <= state_n;
            irq      <= irq_n;
            irq_id   <= irq_id_n;
            irq_addr <= irq_addr_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_n = ACTIVE;
            ACTIVE:  if (irq_ack) state_n = GAP;
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        irq_n      = irq;
        irq_id_n   = irq_id;
        irq_addr_n = irq_addr;
        clr        = '0;
        case (state_q)
            IDLE: begin
                irq_n = 1'b0;
                if (win_vld) begin
                    irq_n      = 1'b1;
                    irq_id_n   = win_id;
                    irq_addr_n = ISR_BASE + ISR_STRIDE * ADDR_W'(win_id);
                end
            end
            ACTIVE: begin
                if (irq_ack) begin
                    irq_n = 1'b0;
                    clr   = N_SRC'(1) << irq_id;
                end
            end
            default: irq_n = 1'b0;
        endcase
    end

    // A fresh edge on the source being acknowledged keeps its pending bit set
    assign pend_n = (pending & ~clr) | src_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q   <= '0;
            held_q  <= irq_src;
            pending <= '0;
        end else begin
            src_q   <= irq_src;
            held_q  <= held_q & irq_src;
            pending <= pend_n;
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed scenarios then random traffic against a cycle-level reference model.
// Mask scenarios are exercised when INTC_MASK_EN is defined.
module tb_interrupt_ctrl;

    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] STRIDE = 32'h0000_0040;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_src;
    logic        irq_ack;
`ifdef INTC_MASK_EN
    logic        mask_we;
    logic [3:0]  mask_wd;
`endif
    logic        irq;
    logic [31:0] irq_addr;
    logic [1:0]  irq_id;
    logic [3:0]  pending;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [3:0]  m_prev, m_held, m_pend, m_mask;
    bit          m_busy, m_gap;
    int          m_id;
    logic [31:0] m_addr;

    interrupt_ctrl #(.ISR_BASE(BASE), .ISR_STRIDE(STRIDE)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .irq_ack  (irq_ack),
`ifdef INTC_MASK_EN
        .mask_we  (mask_we),
        .mask_wd  (mask_wd),
`endif
        .irq      (irq),
        .irq_addr (irq_addr),
        .irq_id   (irq_id),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the behavioural model, using the inputs the DUT is about to sample
    task automatic model_update();
        logic [3:0] e;
        logic [3:0] np;
        bit         found;
        if (rst) begin
            m_prev = 4'b0000;
            m_held = irq_src;
            m_pend = 4'b0000;
            m_busy = 0;
            m_gap  = 0;
            m_id   = 0;
            m_addr = 32'h0;
            m_mask = 4'b1111;
        end else begin
            e  = irq_src & ~m_prev & ~m_held;
            np = m_pend | e;
            if (m_busy) begin
                if (irq_ack) begin
                    np[m_id] = e[m_id];
                    m_busy   = 0;
                    m_gap    = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                found = 0;
                for (int i = 3; i >= 0; i--) begin
                    if (m_pend[i] && m_mask[i]) begin
                        m_id  = i;
                        found = 1;
                    end
                end
                if (found) begin
                    m_busy = 1;
                    m_addr = BASE + STRIDE * 32'(m_id);
                end
            end
`ifdef INTC_MASK_EN
            if (mask_we) m_mask = mask_wd;
`endif
            m_pend = np;
            m_prev = irq_src;
            m_held = m_held & irq_src;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("irq",      32'(irq),      32'(m_busy));
        check("irq_id",   32'(irq_id),   32'(m_id));
        check("irq_addr", irq_addr,      m_addr);
        check("pending",  32'(pending),  32'(m_pend));
    endtask

    initial begin
        rst     = 1'b1;
        irq_src = 4'b0000;
        irq_ack = 1'b0;
`ifdef INTC_MASK_EN
        mask_we = 1'b0;
        mask_wd = 4'b0000;
`endif
        step();
        step();
        check("reset_irq",     32'(irq),     32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_addr",    irq_addr,     32'd0);

        // single source 2
        rst = 1'b0;
        step();
        irq_src = 4'b0100;
        step();
        check("single_pending", 32'(pending), 32'h4);
        check("single_irq_lo",  32'(irq),     32'd0);
        step();
        check("single_irq",  32'(irq),    32'd1);
        check("single_id",   32'(irq_id), 32'd2);
        check("single_addr", irq_addr,    32'h80);
        irq_src = 4'b0000;
        step();
        step();
        check("single_hold", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        step();
        check("single_ack_irq",  32'(irq),     32'd0);
        check("single_ack_pend", 32'(pending), 32'd0);
        irq_ack = 1'b0;
        step();
        step();
        check("single_idle", 32'(irq), 32'd0);

        // priority: sources 1 and 3 together
        irq_src = 4'b1010;
        step();
        step();
        check("prio_first", 32'(irq_id), 32'd1);
        irq_src = 4'b0000;
        irq_ack = 1'b1;
        step();
        check("prio_pend_left", 32'(pending), 32'h8);
        irq_ack = 1'b0;
        step();
        check("prio_gap", 32'(irq), 32'd0);
        step();
        check("prio_second",      32'(irq_id), 32'd3);
        check("prio_second_addr", irq_addr,    32'hC0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        step();

        // ack collides with a fresh edge on the serviced source
        irq_src = 4'b0001;
        step();
        step();
        check("coll_id", 32'(irq_id), 32'd0);
        irq_src = 4'b0000;
        step();
        irq_src = 4'b0001;
        irq_ack = 1'b1;
        step();
        check("coll_pend", 32'(pending), 32'h1);
        check("coll_irq",  32'(irq),     32'd0);
        irq_src = 4'b0000;
        irq_ack = 1'b0;
        step();
        step();
        check("coll_rereq", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        step();

        // reset while servicing source 3, then a stray ack
        irq_src = 4'b1000;
        step();
        step();
        check("rst_mid_id", 32'(irq_id), 32'd3);
        irq_src = 4'b0000;
        rst     = 1'b1;
        step();
        check("rst_mid_irq",  32'(irq),     32'd0);
        check("rst_mid_pend", 32'(pending), 32'd0);
        check("rst_mid_id0",  32'(irq_id),  32'd0);
        check("rst_mid_addr", irq_addr,     32'd0);
        rst     = 1'b0;
        irq_ack = 1'b1;
        step();
        check("stray_ack_irq", 32'(irq), 32'd0);
        irq_ack = 1'b0;
        step();

        // a line held high across reset needs a fall and a rise
        irq_src = 4'b0010;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        check("held_no_edge", 32'(pending), 32'd0);
        irq_src = 4'b0000;
        step();
        irq_src = 4'b0010;
        step();
        check("held_re_edge", 32'(pending), 32'h2);
        step();
        irq_src = 4'b0000;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        step();

`ifdef INTC_MASK_EN
        // masked source still latches pending but is not arbitrated
        mask_we = 1'b1;
        mask_wd = 4'b1110;
        step();
        mask_we = 1'b0;
        irq_src = 4'b0001;
        step();
        step();
        step();
        check("mask_pend", 32'(pending), 32'h1);
        check("mask_irq",  32'(irq),     32'd0);
        mask_we = 1'b1;
        mask_wd = 4'b1111;
        step();
        mask_we = 1'b0;
        step();
        check("unmask_irq", 32'(irq),    32'd1);
        check("unmask_id",  32'(irq_id), 32'd0);
        irq_src = 4'b0000;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        step();
`endif

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            irq_src = 4'($urandom_range(0, 15));
            irq_ack = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 79) == 0);
`ifdef INTC_MASK_EN
            mask_we = ($urandom_range(0, 9) == 0);
            mask_wd = 4'($urandom_range(0, 15));
`endif
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
